// File: rtl/mult_eval_pkg.sv
// mult_eval_pkg: shared state encoding, latency limit and width helpers
// for the multiplier evaluation harness.
package mult_eval_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   localparam int LAT_MAX = 4;
   function automatic int pw(input int w);
      return 2 * w;
   endfunction
   function automatic int cw(input int w);
      return 2 * w + 1;
   endfunction
endpackage

// File: rtl/mult_eval_checker.sv
// mult_eval_checker: delays expected product and operands by the multiplier latency,
// compares against mult_p and tallies mismatches; MULT_EVAL_ERRDIST_EN adds err_dist.
module mult_eval_checker import mult_eval_pkg::*; #(
   parameter int WIDTH   = 2,
   parameter int DUT_LAT = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   in_vld,
   input  logic [pw(WIDTH)-1:0]   in_ab,
   input  logic [pw(WIDTH)-1:0]   mult_p,
   output logic                   empty,
   output logic [cw(WIDTH)-1:0]   err_count,
   output logic [pw(WIDTH)-1:0]   first_fail,
   output logic                   fail_seen
`ifdef MULT_EVAL_ERRDIST_EN
   ,
   output logic [4*WIDTH:0]       err_dist
`endif
);
   localparam int PW = pw(WIDTH);
   localparam int L  = DUT_LAT > LAT_MAX ? LAT_MAX : DUT_LAT;
   logic [PW-1:0] in_exp, d_exp, d_ab;
   logic d_vld, mis;
   assign in_exp = PW'(in_ab[PW-1:WIDTH]) * PW'(in_ab[WIDTH-1:0]);
   generate
      if (L == 0) begin : g_comb
         assign d_vld = in_vld;
         assign d_exp = in_exp;
         assign d_ab  = in_ab;
         assign empty = 1'b1;
      end else begin : g_pipe
         logic [L-1:0]  v_q;
         logic [PW-1:0] e_q [L];
         logic [PW-1:0] a_q [L];
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
               v_q <= '0;
               for (int i = 0; i < L; i++) begin
                  e_q[i] <= '0;
                  a_q[i] <= '0;
               end
            end else begin
               v_q <= L'({v_q, in_vld});
               for (int i = L - 1; i > 0; i--) begin
                  e_q[i] <= e_q[i-1];
                  a_q[i] <= a_q[i-1];
               end
               e_q[0] <= in_exp;
               a_q[0] <= in_ab;
            end
         assign d_vld = v_q[L-1];
         assign d_exp = e_q[L-1];
         assign d_ab  = a_q[L-1];
         assign empty = ~|v_q;
      end
   endgenerate
   assign mis = d_vld && (mult_p != d_exp);
   // err_count cannot overflow: at most one increment per pair, 2^(2W) pairs
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         err_count  <= '0;
         first_fail <= '0;
         fail_seen  <= 1'b0;
      end else if (clr) begin
         err_count  <= '0;
         first_fail <= '0;
         fail_seen  <= 1'b0;
      end else if (mis) begin
         err_count <= err_count + 1'b1;
         if (!fail_seen) begin
            first_fail <= d_ab;
            fail_seen  <= 1'b1;
         end
      end
`ifdef MULT_EVAL_ERRDIST_EN
   logic [PW-1:0] dist;
   assign dist = mult_p > d_exp ? mult_p - d_exp : d_exp - mult_p;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_dist <= '0;
      else if (clr) err_dist <= '0;
      else if (d_vld) err_dist <= err_dist + (4*WIDTH+1)'(dist);
`endif
endmodule

// File: rtl/mult_eval_harness.sv
// mult_eval_harness: sweeps every operand pair through an external multiplier and scores it.
// Optional MULT_EVAL_ERRDIST_EN adds the err_dist accumulated-distance output.
module mult_eval_harness import mult_eval_pkg::*; #(
   parameter int WIDTH   = 2,
   parameter int DUT_LAT = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic [WIDTH-1:0]       mult_a,
   output logic [WIDTH-1:0]       mult_b,
   input  logic [pw(WIDTH)-1:0]   mult_p,
   output logic                   busy,
   output logic                   done,
   output logic [cw(WIDTH)-1:0]   err_count,
   output logic [pw(WIDTH)-1:0]   first_fail,
   output logic                   fail_seen
`ifdef MULT_EVAL_ERRDIST_EN
   ,
   output logic [4*WIDTH:0]       err_dist
`endif
);
   state_t state;
   logic [pw(WIDTH)-1:0] ab;
   logic go, empty;
   assign go = start && (state == IDLE || state == DONE);
   assign {mult_a, mult_b} = ab;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         ab    <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE:
               if (go) begin
                  state <= RUN;
                  ab    <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            RUN:
               if (&ab) state <= DRAIN;
               else ab <= ab + 1'b1;
            DRAIN:
               if (empty) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
   mult_eval_checker #(.WIDTH(WIDTH), .DUT_LAT(DUT_LAT)) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (go),
      .in_vld    (state == RUN),
      .in_ab     (ab),
      .mult_p    (mult_p),
      .empty     (empty),
      .err_count (err_count),
      .first_fail(first_fail),
      .fail_seen (fail_seen)
`ifdef MULT_EVAL_ERRDIST_EN
      ,
      .err_dist  (err_dist)
`endif
   );
endmodule

// File: tb/tb_mult_eval_harness.sv
// tb_mult_eval_harness: directed bench for two harness instances (latency 0 and 2) with
// behavioural multipliers; err_dist checked when MULT_EVAL_ERRDIST_EN is defined.
module tb_mult_eval_harness;
   logic clk = 0, rst_n = 0, start0 = 0, start2 = 0;
   logic [1:0] a0, b0, a2, b2;
   logic [3:0] ex0, p0, p2, r1, r2;
   logic busy0, done0, busy2, done2, fs0, fs2;
   logic [4:0] ec0, ec2;
   logic [3:0] ff0, ff2;
`ifdef MULT_EVAL_ERRDIST_EN
   logic [8:0] ed0, ed2;
`endif
   int mode = 0, tests = 0, fails = 0, n = 0;
   always #5 clk = ~clk;
   // mode 0 exact, 1 tied to zero, 2 exact with LSB flipped
   assign ex0 = {2'b0, a0} * {2'b0, b0};
   assign p0 = mode == 0 ? ex0 : mode == 1 ? 4'd0 : ex0 ^ 4'd1;
   always_ff @(posedge clk) begin
      r1 <= {2'b0, a2} * {2'b0, b2};
      r2 <= r1;
   end
   assign p2 = r2;
   mult_eval_harness #(.WIDTH(2), .DUT_LAT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .mult_a(a0), .mult_b(b0), .mult_p(p0),
      .busy(busy0), .done(done0), .err_count(ec0), .first_fail(ff0), .fail_seen(fs0)
`ifdef MULT_EVAL_ERRDIST_EN
      , .err_dist(ed0)
`endif
   );
   mult_eval_harness #(.WIDTH(2), .DUT_LAT(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .mult_a(a2), .mult_b(b2), .mult_p(p2),
      .busy(busy2), .done(done2), .err_count(ec2), .first_fail(ff2), .fail_seen(fs2)
`ifdef MULT_EVAL_ERRDIST_EN
      , .err_dist(ed2)
`endif
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   // counts clocks from raising start until done is seen, bounded at 200
   task automatic sweep(input bit sel, input int poke, output int cnt);
      cnt = 0;
      @(negedge clk);
      if (sel) start2 = 1; else start0 = 1;
      @(negedge clk);
      start0 = 0; start2 = 0; cnt = 1;
      while (!(sel ? done2 : done0) && cnt < 200) begin
         if (cnt == poke) start0 = 1;
         @(negedge clk);
         start0 = 0;
         cnt++;
      end
   endtask
   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", busy0, 0); check("rst_done", done0, 0);
      check("rst_a", a0, 0); check("rst_b", b0, 0);
      check("rst_err", ec0, 0); check("rst_ff", ff0, 0); check("rst_fs", fs0, 0);
      check("rst_done2", done2, 0);
      rst_n = 1;
      mode = 0;
      sweep(0, 0, n);
      check("exact_time", n, 18); check("exact_err", ec0, 0); check("exact_fs", fs0, 0);
      check("exact_busy", busy0, 0); check("exact_a_hold", a0, 3); check("exact_b_hold", b0, 3);
      mode = 1;
      sweep(0, 0, n);
      check("zero_time", n, 18); check("zero_err", ec0, 9);
      check("zero_ff", ff0, 4'b0101); check("zero_fs", fs0, 1);
`ifdef MULT_EVAL_ERRDIST_EN
      check("zero_dist", ed0, 36);
`endif
      repeat (3) @(negedge clk);
      check("zero_hold_err", ec0, 9); check("zero_hold_done", done0, 1);
      mode = 2;
      sweep(0, 0, n);
      check("xor_err", ec0, 16); check("xor_ff", ff0, 0); check("xor_fs", fs0, 1);
`ifdef MULT_EVAL_ERRDIST_EN
      check("xor_dist", ed0, 16);
`endif
      sweep(1, 0, n);
      check("lat2_time", n, 20); check("lat2_err", ec2, 0); check("lat2_fs", fs2, 0);
      mode = 1;
      sweep(0, 5, n);
      check("ignore_time", n, 18); check("ignore_err", ec0, 9); check("ignore_ff", ff0, 5);
      @(negedge clk); start0 = 1;
      @(negedge clk); start0 = 0;
      repeat (6) @(negedge clk);
      check("mid_busy", busy0, 1); check("mid_a", a0, 1); check("mid_b", b0, 2);
      check("mid_err", ec0, 1); check("mid_ff", ff0, 5);
      rst_n = 0;
      #1;
      check("arst_busy", busy0, 0); check("arst_done", done0, 0);
      check("arst_a", a0, 0); check("arst_b", b0, 0);
      check("arst_err", ec0, 0); check("arst_ff", ff0, 0); check("arst_fs", fs0, 0);
      @(negedge clk); rst_n = 1;
      mode = 0;
      sweep(0, 0, n);
      check("post_time", n, 18); check("post_err", ec0, 0); check("post_fs", fs0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
